// File: rtl/voice_frame_pkg.sv
// Shared constants and types for the voice frame ping-pong buffer:
// register map, status/control bit positions and capture FSM states.
package voice_frame_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_READY     = 0;
    localparam int ST_ENABLE    = 1;
    localparam int ST_HOLD      = 2;
    localparam int ST_OVR_LSB   = 8;
    localparam int ST_RDPTR_LSB = 16;

    localparam int CTRL_ACK     = 0;
    localparam int CTRL_ENABLE  = 1;
    localparam int CTRL_CLR_OVR = 2;

    localparam int OVERRUN_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD
    } cap_state_t;

endpackage

// File: rtl/frame_bank_ram.sv
// Simple dual-port synchronous RAM holding both frame banks, addressed as {bank, ptr}.
// The read port only updates on read enable so its output holds between CPU reads.
module frame_bank_ram #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/voice_frame_buffer.sv
// Ping-pong capture buffer: packs codec samples into frames in alternating banks
// and exposes the completed frame to the CPU through a small Avalon-MM slave.
module voice_frame_buffer
    import voice_frame_pkg::*;
#(
    parameter int SAMPLE_W  = 16,
    parameter int FRAME_LEN = 256
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                read_n,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic                request
);

    localparam int PTR_W = $clog2(FRAME_LEN);

    cap_state_t state, state_next;

    logic                 wr_bank;
    logic                 ready_bank;
    logic                 ready;
    logic                 enable;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [OVERRUN_W-1:0] overrun;

    logic do_write, do_swap, do_drop;
    logic rd_strobe, wr_strobe, ctrl_wr, ack, data_rd, wr_last;

    logic [SAMPLE_W-1:0] ram_q;
    logic [31:0]         reg_rdata;
    logic [31:0]         status_word;
    logic [31:0]         ctrl_word;
    logic                data_sel;
    logic                unused_wdata;

    assign rd_strobe    = chipselect & ~read_n;
    assign wr_strobe    = chipselect & ~write_n;
    assign ctrl_wr      = wr_strobe && (address == REG_CTRL);
    assign ack          = ctrl_wr & writedata[CTRL_ACK];
    assign data_rd      = rd_strobe && (address == REG_DATA) && ready;
    assign wr_last      = (wr_ptr == PTR_W'(FRAME_LEN - 1));
    assign unused_wdata = ^writedata[31:3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An ack arriving with the last sample frees the CPU bank in time, so swap instead of holding.
    always_comb begin
        state_next = state;
        do_write   = 1'b0;
        do_swap    = 1'b0;
        do_drop    = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: state_next = FILL;
                FILL: begin
                    if (sample_valid) begin
                        do_write = 1'b1;
                        if (wr_last) begin
                            if (!ready || ack) begin
                                do_swap = 1'b1;
                            end else begin
                                state_next = HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    do_drop = sample_valid;
                    if (!ready) begin
                        do_swap    = 1'b1;
                        state_next = FILL;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_bank <= 1'b0;
            wr_ptr  <= '0;
        end else if (!enable) begin
            wr_ptr <= '0;
        end else if (do_swap) begin
            wr_bank <= ~wr_bank;
            wr_ptr  <= '0;
        end else if (do_write) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready      <= 1'b0;
            ready_bank <= 1'b0;
            rd_ptr     <= '0;
        end else if (do_swap) begin
            ready      <= 1'b1;
            ready_bank <= wr_bank;
            rd_ptr     <= '0;
        end else if (ack && ready) begin
            ready  <= 1'b0;
            rd_ptr <= '0;
        end else if (data_rd) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable  <= 1'b0;
            overrun <= '0;
        end else begin
            if (ctrl_wr) begin
                enable <= writedata[CTRL_ENABLE];
            end
            if (ctrl_wr && writedata[CTRL_CLR_OVR]) begin
                overrun <= '0;
            end else if (do_drop && (overrun != {OVERRUN_W{1'b1}})) begin
                overrun <= overrun + OVERRUN_W'(1);
            end
        end
    end

    always_comb begin
        status_word = '0;
        status_word[ST_READY]                 = ready;
        status_word[ST_ENABLE]                = enable;
        status_word[ST_HOLD]                  = (state == HOLD);
        status_word[ST_OVR_LSB +: OVERRUN_W]  = overrun;
        status_word[ST_RDPTR_LSB +: PTR_W]    = rd_ptr;
        ctrl_word = '0;
        ctrl_word[CTRL_ENABLE]                = enable;
    end

    // Sample reads come straight from the RAM output register; everything else from reg_rdata.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_sel  <= 1'b0;
            reg_rdata <= '0;
        end else if (rd_strobe) begin
            data_sel <= data_rd;
            case (address)
                REG_STATUS: reg_rdata <= status_word;
                REG_CTRL:   reg_rdata <= ctrl_word;
                default:    reg_rdata <= '0;
            endcase
        end
    end

    assign readdata = data_sel ? 32'(signed'(ram_q)) : reg_rdata;
    assign request  = ready;

    frame_bank_ram #(
        .WIDTH  (SAMPLE_W),
        .DEPTH  (2 * FRAME_LEN),
        .ADDR_W (PTR_W + 1)
    ) u_ram (
        .clk   (clk),
        .we    (do_write),
        .waddr ({wr_bank, wr_ptr}),
        .wdata (sample_data),
        .re    (data_rd),
        .raddr ({ready_bank, rd_ptr}),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_voice_frame_buffer.sv
// Directed bench for voice_frame_buffer (FRAME_LEN=4) with a frame-queue reference model
// checked every cycle, plus literal expectations on the key scenarios.
module tb_voice_frame_buffer;

    localparam int SW = 16;
    localparam int FL = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          sample_valid;
    logic [SW-1:0] sample_data;
    logic [1:0]    address;
    logic          chipselect;
    logic          read_n;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic          request;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    voice_frame_buffer #(.SAMPLE_W(SW), .FRAME_LEN(FL)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .address      (address),
        .chipselect   (chipselect),
        .read_n       (read_n),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .request      (request)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frames as queues; a completed frame either goes to the CPU or waits.
    bit            m_en, m_active, m_wait, m_ready;
    int            m_rd, m_ovr;
    logic [31:0]   m_rdata;
    logic [SW-1:0] rframe [FL];
    logic [SW-1:0] cur[$], pending[$], nf[$];
    bit            rd_s, wr_s, ack_s, pub;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_en = 0; m_active = 0; m_wait = 0; m_ready = 0;
            m_rd = 0; m_ovr = 0; m_rdata = '0;
            cur.delete(); pending.delete();
        end else begin
            rd_s  = chipselect && !read_n;
            wr_s  = chipselect && !write_n;
            ack_s = wr_s && (address == 2'd2) && writedata[0];
            if (rd_s) begin
                case (address)
                    2'd0: begin
                        if (m_ready) begin
                            m_rdata = {{16{rframe[m_rd][SW-1]}}, rframe[m_rd]};
                            m_rd = (m_rd + 1) % FL;
                        end else begin
                            m_rdata = '0;
                        end
                    end
                    2'd1: m_rdata = {16'(m_rd), 8'(m_ovr), 5'b0, m_wait, m_en, m_ready};
                    2'd2: m_rdata = {30'b0, m_en, 1'b0};
                    default: m_rdata = '0;
                endcase
            end
            pub = 0;
            if (!m_en) begin
                m_active = 0; m_wait = 0;
                cur.delete(); pending.delete();
            end else if (!m_active) begin
                m_active = 1;
            end else if (m_wait) begin
                if (sample_valid && m_ovr < 255) m_ovr++;
                if (!m_ready) begin
                    nf = pending; pending.delete(); m_wait = 0; pub = 1;
                end
            end else if (sample_valid) begin
                cur.push_back(sample_data);
                if (cur.size() == FL) begin
                    if (!m_ready || ack_s) begin
                        nf = cur; pub = 1;
                    end else begin
                        pending = cur; m_wait = 1;
                    end
                    cur.delete();
                end
            end
            if (pub) begin
                for (int i = 0; i < FL; i++) rframe[i] = nf[i];
                m_ready = 1; m_rd = 0;
            end else if (ack_s && m_ready) begin
                m_ready = 0; m_rd = 0;
            end
            if (wr_s && address == 2'd2) begin
                m_en = writedata[1];
                if (writedata[2]) m_ovr = 0;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("request_vs_model", {31'b0, request}, {31'b0, m_ready});
        checkOutput("readdata_vs_model", readdata, m_rdata);
    end

    task automatic applyStimulus(input logic sv, input logic [SW-1:0] sd, input logic cs,
                                 input logic rd, input logic wr, input logic [1:0] addr,
                                 input logic [31:0] wd);
        sample_valid = sv; sample_data = sd; chipselect = cs;
        read_n = ~rd; write_n = ~wr; address = addr; writedata = wd;
        @(negedge clk);
        sample_valid = 1'b0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic pushSample(input logic [SW-1:0] d);
        applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic regWrite(input logic [1:0] a, input logic [31:0] d);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic regReadCheck(input string name, input logic [1:0] a, input logic [31:0] exp);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0, a, 32'd0);
        checkOutput(name, readdata, exp);
    endtask

    initial begin
        reset_n = 1'b0; sample_valid = 1'b0; sample_data = '0; address = '0;
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; writedata = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_request", {31'b0, request}, 32'd0);
        checkOutput("reset_readdata", readdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        regReadCheck("reset_status", 2'd1, 32'h0000_0000);

        // Basic frame with sign extension and read-pointer wrap
        regWrite(2'd2, 32'h2);
        idleCycle();
        regReadCheck("ctrl_readback", 2'd2, 32'h0000_0002);
        pushSample(16'h0001); pushSample(16'h8000); pushSample(16'h7FFF);
        checkOutput("request_before_last", {31'b0, request}, 32'd0);
        pushSample(16'h0003);
        checkOutput("request_after_last", {31'b0, request}, 32'd1);
        regReadCheck("basic_d0", 2'd0, 32'h0000_0001);
        regReadCheck("basic_d1", 2'd0, 32'hFFFF_8000);
        regReadCheck("basic_d2", 2'd0, 32'h0000_7FFF);
        regReadCheck("basic_d3", 2'd0, 32'h0000_0003);
        regReadCheck("basic_wrap", 2'd0, 32'h0000_0001);

        // Overrun while the CPU holds its frame
        for (int i = 0; i < 4; i++) pushSample(16'(16'h10 + i));
        for (int i = 0; i < 3; i++) pushSample(16'h0099);
        regReadCheck("hold_status", 2'd1, 32'h0001_0307);
        regWrite(2'd2, 32'h3);
        checkOutput("ack_hold_low", {31'b0, request}, 32'd0);
        idleCycle();
        checkOutput("ack_hold_high", {31'b0, request}, 32'd1);
        for (int i = 0; i < 4; i++) regReadCheck("hold_frame", 2'd0, 32'(32'h10 + i));

        // Ack on the same edge as the last sample: swap wins, pointer restarts
        regReadCheck("pre_ack_read", 2'd0, 32'h0000_0010);
        pushSample(16'h0021); pushSample(16'h0022); pushSample(16'h0023);
        applyStimulus(1'b1, 16'h0024, 1'b1, 1'b0, 1'b1, 2'd2, 32'h3);
        checkOutput("ack_last_request", {31'b0, request}, 32'd1);
        for (int i = 0; i < 4; i++) regReadCheck("ack_last_frame", 2'd0, 32'(32'h21 + i));
        regWrite(2'd2, 32'h6);
        regReadCheck("overrun_cleared", 2'd1, 32'h0000_0003);

        // Disable mid-frame discards the partial frame
        regWrite(2'd2, 32'h3);
        pushSample(16'h0055); pushSample(16'h0066);
        regWrite(2'd2, 32'h0);
        regWrite(2'd2, 32'h2);
        idleCycle();
        for (int i = 0; i < 4; i++) pushSample(16'(16'hA + i));
        checkOutput("disable_request", {31'b0, request}, 32'd1);
        for (int i = 0; i < 4; i++) regReadCheck("disable_frame", 2'd0, 32'(32'hA + i));

        // Empty read returns zero and leaves the pointer alone
        regWrite(2'd2, 32'h3);
        regReadCheck("empty_data", 2'd0, 32'h0000_0000);
        regReadCheck("empty_status", 2'd1, 32'h0000_0002);

        // Overrun saturation, then asynchronous reset mid-traffic
        for (int i = 0; i < 4; i++) pushSample(16'(i + 1));
        for (int i = 0; i < 4; i++) pushSample(16'h0042);
        for (int i = 0; i < 260; i++) pushSample(16'h0077);
        regReadCheck("overrun_saturated", 2'd1, 32'h0000_FF07);
        sample_valid = 1'b1; sample_data = 16'h1234;
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midreset_request", {31'b0, request}, 32'd0);
        checkOutput("midreset_readdata", readdata, 32'd0);
        @(negedge clk);
        sample_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        regReadCheck("midreset_status", 2'd1, 32'h0000_0000);
        idleCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
